dadda_mult_pipe: RTL and testbench

//  Parametrised, pipelined Dadda-tree multiplier for signed or unsigned operands.
//  It generalises the team's combinational 8x8 Dadda multiplier to any width, with a
//  per-transaction signed/unsigned mode, a fixed 3-cycle latency and valid/ready

---
 rtl/dadda_mult_pipe.sv | 143 ++++++++++++++
 tb/tb_dadda_mult_pipe.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/dadda_mult_pipe.sv
// Pipelined WIDTH x WIDTH Dadda-tree multiplier, signed (Baugh-Wooley) or unsigned per
// transaction, 3-cycle latency, rigid valid/ready pipeline that stalls as a whole.
module dadda_mult_pipe #(
    parameter int WIDTH = 8,
    parameter int TAG_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    input  logic               in_signed,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out_prod,
    output logic [TAG_W-1:0]   out_tag
);
    localparam int PW     = 2 * WIDTH;
    localparam int STAGES = 3;
    localparam int DADDA_D [8] = '{2, 3, 4, 6, 9, 13, 19, 28};

    logic               adv, acc;
    logic [STAGES:1]    vld_pipe;
    logic [WIDTH-1:0]   s1_a, s1_b;
    logic               s1_sgn;
    logic [TAG_W-1:0]   s1_tag, s2_tag, s3_tag;
    logic [PW-1:0]      row0, row1, s2_r0, s2_r1, s3_prod;

    assign adv       = !vld_pipe[STAGES] || out_ready;
    assign in_ready  = adv;
    assign acc       = in_valid && adv;
    assign out_valid = vld_pipe[STAGES];
    assign out_prod  = s3_prod;
    assign out_tag   = s3_tag;

    // Matrix is built as per-column bit stacks; heights depend only on WIDTH, so the
    // loops below unroll into a fixed adder tree.
    always_comb begin : reduce
        logic m  [PW][WIDTH];
        logic nm [PW][WIDTH];
        int   h  [PW];
        int   nh [PW];
        int   tot, src, d;
        logic x, y, z, sm, cy;
        row0 = '0;
        row1 = '0;
        x = 1'b0; y = 1'b0; z = 1'b0; sm = 1'b0; cy = 1'b0;
        tot = 0; src = 0; d = 0;
        for (int c = 0; c < PW; c++) begin
            h[c]  = 0;
            nh[c] = 0;
            for (int r = 0; r < WIDTH; r++) begin
                m[c][r]  = 1'b0;
                nm[c][r] = 1'b0;
            end
        end
        // Baugh-Wooley: terms with exactly one operand MSB are inverted in signed mode
        for (int i = 0; i < WIDTH; i++) begin
            for (int j = 0; j < WIDTH; j++) begin
                x = s1_a[i] & s1_b[j];
                if ((i == WIDTH-1) != (j == WIDTH-1)) x = x ^ s1_sgn;
                m[i+j][h[i+j]] = x;
                h[i+j] = h[i+j] + 1;
            end
        end
        m[WIDTH][h[WIDTH]] = s1_sgn;
        h[WIDTH] = h[WIDTH] + 1;
        m[PW-1][h[PW-1]] = s1_sgn;
        h[PW-1] = h[PW-1] + 1;

        for (int k = 7; k >= 0; k--) begin
            d = DADDA_D[k];
            if (d < WIDTH) begin
                for (int c = 0; c < PW; c++) begin
                    nh[c] = 0;
                    for (int r = 0; r < WIDTH; r++) nm[c][r] = 1'b0;
                end
                for (int c = 0; c < PW; c++) begin
                    // carries already dropped into this column count toward its height
                    tot = h[c] + nh[c];
                    src = 0;
                    for (int t = 0; t < WIDTH; t++) begin
                        if (tot > d && src + 1 < h[c]) begin
                            x = m[c][src];
                            y = m[c][src+1];
                            if (tot == d + 1 || src + 2 >= h[c]) begin
                                sm  = x ^ y;
                                cy  = x & y;
                                src = src + 2;
                                tot = tot - 1;
                            end else begin
                                z   = m[c][src+2];
                                sm  = x ^ y ^ z;
                                cy  = (x & y) | (x & z) | (y & z);
                                src = src + 3;
                                tot = tot - 2;
                            end
                            nm[c][nh[c]] = sm;
                            nh[c] = nh[c] + 1;
                            if (c + 1 < PW) begin
                                nm[c+1][nh[c+1]] = cy;
                                nh[c+1] = nh[c+1] + 1;
                            end
                        end
                    end
                    for (int r = 0; r < WIDTH; r++) begin
                        if (r >= src && r < h[c]) begin
                            nm[c][nh[c]] = m[c][r];
                            nh[c] = nh[c] + 1;
                        end
                    end
                end
                m = nm;
                h = nh;
            end
        end
        for (int c = 0; c < PW; c++) begin
            if (h[c] > 0) row0[c] = m[c][0];
            if (h[c] > 1) row1[c] = m[c][1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe <= '0;
            s3_prod  <= '0;
            s3_tag   <= '0;
        end else if (adv) begin
            vld_pipe <= {vld_pipe[STAGES-1:1], acc};
            s1_a     <= in_a;
            s1_b     <= in_b;
            s1_sgn   <= in_signed;
            s1_tag   <= in_tag;
            s2_r0    <= row0;
            s2_r1    <= row1;
            s2_tag   <= s1_tag;
            s3_prod  <= s2_r0 + s2_r1;
            s3_tag   <= s2_tag;
        end
    end
endmodule

// File: tb/tb_dadda_mult_pipe.sv
// Bench for dadda_mult_pipe: WIDTH 8/13/16 instances share one stimulus stream,
// each with its own expected-result queue keyed by tag and product.
module tb_dadda_mult_pipe;
    localparam int WID [3] = '{8, 13, 16};

    logic        clk = 1'b0;
    logic        rst, in_valid, in_signed, out_ready;
    logic [31:0] a, b;
    logic [3:0]  tag;

    wire  [2:0]  ir, ov;
    wire  [15:0] p8;
    wire  [25:0] p13;
    wire  [31:0] p16;
    wire  [3:0]  t8, t13, t16;
    wire  [31:0] mp [3];
    wire  [3:0]  mt [3];

    int checks = 0, failures = 0, n_acc = 0;
    logic [35:0] sbq [3][$];

    always #5 clk = ~clk;

    dadda_mult_pipe #(.WIDTH(8), .TAG_W(4)) u8 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[0]), .in_a(a[7:0]),
        .in_b(b[7:0]), .in_signed(in_signed), .in_tag(tag), .out_valid(ov[0]),
        .out_ready(out_ready), .out_prod(p8), .out_tag(t8));
    dadda_mult_pipe #(.WIDTH(13), .TAG_W(4)) u13 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[1]), .in_a(a[12:0]),
        .in_b(b[12:0]), .in_signed(in_signed), .in_tag(tag), .out_valid(ov[1]),
        .out_ready(out_ready), .out_prod(p13), .out_tag(t13));
    dadda_mult_pipe #(.WIDTH(16), .TAG_W(4)) u16 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[2]), .in_a(a[15:0]),
        .in_b(b[15:0]), .in_signed(in_signed), .in_tag(tag), .out_valid(ov[2]),
        .out_ready(out_ready), .out_prod(p16), .out_tag(t16));

    assign mp[0] = {16'b0, p8};
    assign mp[1] = {6'b0, p13};
    assign mp[2] = p16;
    assign mt[0] = t8;
    assign mt[1] = t13;
    assign mt[2] = t16;

    function automatic logic [31:0] model(int w, logic [31:0] x, logic [31:0] y, logic s);
        longint xm, ym, p, one;
        one = 1;
        xm  = longint'({32'b0, x}) & ((one << w) - 1);
        ym  = longint'({32'b0, y}) & ((one << w) - 1);
        if (s && x[w-1]) xm = xm - (one << w);
        if (s && y[w-1]) ym = ym - (one << w);
        p = (xm * ym) & ((one << (2*w)) - 1);
        return p[31:0];
    endfunction

    task automatic chk(string name, logic [35:0] got, logic [35:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%h want=%h", name, got, exp);
        end
    endtask

    // Runs at the negedge: scoreboard pop on out handshake, push on in handshake.
    task automatic monitor();
        logic [35:0] e;
        for (int g = 0; g < 3; g++) begin
            if (rst) begin
                sbq[g].delete();
            end else begin
                chk($sformatf("in_ready_w%0d", WID[g]), 36'(ir[g]), 36'(!ov[g] || out_ready));
                if (ov[g] && out_ready) begin
                    checks++;
                    assert (sbq[g].size() != 0) else begin
                        failures++;
                        $error("FAIL unexpected_out_w%0d got=%h want=none", WID[g], mp[g]);
                    end
                    if (sbq[g].size() != 0) begin
                        e = sbq[g].pop_front();
                        chk($sformatf("result_w%0d", WID[g]), {mt[g], mp[g]}, e);
                    end
                end
                if (in_valid && ir[g]) begin
                    sbq[g].push_back({tag, model(WID[g], a, b, in_signed)});
                    if (g == 0) n_acc++;
                end
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(logic v, logic s, logic [31:0] xa, logic [31:0] xb, logic [3:0] t);
        in_valid  = v;
        in_signed = s;
        a         = xa;
        b         = xb;
        tag       = t;
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h1;
            3:       return 32'h80;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        rst = 1'b1; out_ready = 1'b1;
        drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        @(posedge clk); #1;
        tick(); tick();
        rst = 1'b0;
        chk("reset_out_valid", 36'(ov[0]), 36'h0);
        chk("reset_out_prod", 36'(mp[0]), 36'h0);
        chk("reset_out_tag", 36'(mt[0]), 36'h0);
        chk("reset_in_ready", 36'(ir[0]), 36'h1);

        // unsigned 255*255, latency exactly 3 cycles
        drive(1'b1, 1'b0, 32'hFF, 32'hFF, 4'h5);
        tick();
        in_valid = 1'b0;
        chk("lat_c1_valid", 36'(ov[0]), 36'h0);
        tick();
        chk("lat_c2_valid", 36'(ov[0]), 36'h0);
        tick();
        chk("lat_c3_valid", 36'(ov[0]), 36'h1);
        chk("uns_ff_ff", 36'(mp[0]), 36'hFE01);
        tick();

        // back-to-back with mode toggling
        drive(1'b1, 1'b1, 32'h80, 32'h80, 4'h1); tick();
        drive(1'b1, 1'b0, 32'hFF, 32'h7F, 4'h2); tick();
        drive(1'b1, 1'b1, 32'hFF, 32'h7F, 4'h3); tick();
        in_valid = 1'b0;
        chk("sgn_80_80", {mt[0], mp[0]}, {4'h1, 32'h4000});
        tick();
        chk("uns_ff_7f", {mt[0], mp[0]}, {4'h2, 32'h7E81});
        tick();
        chk("sgn_ff_7f", {mt[0], mp[0]}, {4'h3, 32'hFF81});
        tick();
        chk("b2b_drained", 36'(ov[0]), 36'h0);

        // backpressure
        drive(1'b1, 1'b0, 32'h3, 32'h5, 4'h1); tick();
        drive(1'b1, 1'b0, 32'd200, 32'd100, 4'h2); tick();
        drive(1'b1, 1'b1, 32'hFD, 32'h7, 4'h3); tick();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall_valid", 36'(ov[0]), 36'h1);
            chk("stall_in_ready", 36'(ir[0]), 36'h0);
            chk("stall_hold", {mt[0], mp[0]}, {4'h1, 32'h000F});
        end
        out_ready = 1'b1;
        tick();
        chk("rel_tag2", {mt[0], mp[0]}, {4'h2, 32'h4E20});
        tick();
        chk("rel_tag3", {mt[0], mp[0]}, {4'h3, 32'hFFEB});
        tick();
        chk("rel_drained", 36'(ov[0]), 36'h0);

        // reset mid-operation, with a concurrent in_valid that reset must override
        drive(1'b1, 1'b0, 32'h11, 32'h22, 4'h7); tick();
        drive(1'b1, 1'b1, 32'h33, 32'h44, 4'h8); tick();
        drive(1'b1, 1'b0, 32'h55, 32'h66, 4'h9);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        in_valid = 1'b0;
        chk("rst_mid_in_ready", 36'(ir[0]), 36'h1);
        chk("rst_mid_prod", 36'(mp[0]), 36'h0);
        chk("rst_mid_tag", 36'(mt[0]), 36'h0);
        for (int i = 0; i < 5; i++) begin
            chk("rst_mid_no_out", 36'(ov[0]), 36'h0);
            tick();
        end

        // random traffic on all three widths
        n_acc = 0;
        for (int cyc = 0; cyc < 60000 && n_acc < 10000; cyc++) begin
            drive($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), pick(), pick(),
                  4'(n_acc));
            out_ready = $urandom_range(0, 3) != 0;
            tick();
        end
        checks++;
        assert (n_acc >= 10000) else begin
            failures++;
            $error("FAIL random_budget got=%0d want=10000", n_acc);
        end

        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        for (int g = 0; g < 3; g++)
            chk($sformatf("drain_w%0d", WID[g]), 36'(sbq[g].size()), 36'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
